// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register responder.
//   - AXI-Lite response codes (OKAY / SLVERR).
//   - Write and read FSM state encodings.
//   - idx_in_range(): bank-bounds test for a decoded word index.
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    // Write FSM
    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_HAVE_ADDR = 2'd1;
    localparam logic [1:0] W_HAVE_DATA = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;

    // Read FSM
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned depth);
        return idx < depth;
    endfunction

endpackage

// File: rtl/axil_regfile.sv
// Word-organised register storage for axil_reg_responder.
//   clk, rst  : clock, asynchronous active-high clear of every word
//   we_i      : write enable; waddr_i selects the word
//   wdata_i   : write data; wbe_i gives one enable per byte
//   raddr_i   : combinational read address; rdata_o is the current word
// A write lands on the clock edge, so a read of the same word in the same cycle
// still sees the old contents.
module axil_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned BW        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BW-1:0]         wbe_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (wbe_i[b]) begin
                    mem_d[waddr_i][8*b +: 8] = wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite slave serving a DEPTH-word register bank.
//   clk, rst        : clock, asynchronous active-high reset
//   s_axil_aw*      : write address channel (byte address, word index = addr[ADDR_WIDTH-1:2])
//   s_axil_w*       : write data channel with byte strobes
//   s_axil_b*       : write response channel
//   s_axil_ar*      : read address channel
//   s_axil_r*       : read data/response channel
// Out-of-range words answer SLVERR; such writes are dropped and reads return 0.
// Build option: define AXIL_REG_WSTRB_EN to honour s_axil_wstrb per byte; when it is
// undefined every in-range write replaces the whole word.
module axil_reg_responder
    import axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned RF_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ---------------- write channel state ----------------
    logic [1:0]            w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q,  w_strb_d;
    logic [1:0]            bresp_q,   bresp_d;

    // ---------------- read channel state ----------------
    logic [0:0]            r_state_q, r_state_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;

    logic aw_hs, w_hs, ar_hs;

    // Commit path: address/data either straight from the bus or from the latch
    logic                  commit;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_WIDTH-1:0] c_strb;
    logic [IDX_W-1:0]      c_idx;
    logic                  c_in_range;

    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_in_range;

    logic                  rf_we;
    logic [STRB_WIDTH-1:0] rf_be;
    logic [DATA_WIDTH-1:0] rf_rdata;

    assign s_axil_awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_DATA);
    assign s_axil_wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_ADDR);
    assign s_axil_bvalid  = (w_state_q == W_RESP);
    assign s_axil_bresp   = bresp_q;

    assign s_axil_arready = (r_state_q == R_IDLE);
    assign s_axil_rvalid  = (r_state_q == R_RESP);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

    assign aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_hs  = s_axil_wvalid  & s_axil_wready;
    assign ar_hs = s_axil_arvalid & s_axil_arready;

    assign c_idx       = c_addr[ADDR_WIDTH-1:2];
    assign c_in_range  = idx_in_range(32'(c_idx), DEPTH);
    assign ar_idx      = s_axil_araddr[ADDR_WIDTH-1:2];
    assign ar_in_range = idx_in_range(32'(ar_idx), DEPTH);

    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bresp_d   = bresp_q;
        commit    = 1'b0;
        c_addr    = s_axil_awaddr;
        c_data    = s_axil_wdata;
        c_strb    = s_axil_wstrb;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs) begin
                    aw_addr_d = s_axil_awaddr;
                    w_state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_data_d  = s_axil_wdata;
                    w_strb_d  = s_axil_wstrb;
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                c_addr = aw_addr_q;
                if (w_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                c_data = w_data_q;
                c_strb = w_strb_q;
                if (aw_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        if (commit) begin
            bresp_d = c_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        end
    end

    assign rf_we = commit & c_in_range;

`ifdef AXIL_REG_WSTRB_EN
    assign rf_be = c_strb;
`else
    // Strobes are accepted on the bus but every in-range write covers the full word.
    assign rf_be = '1;
    logic unused_strb;
    assign unused_strb = ^c_strb;
`endif

    // Byte offset bits never take part in decode.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{c_addr[1:0], s_axil_araddr[1:0]};

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d   = ar_in_range ? rf_rdata : '0;
                    rresp_d   = ar_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axil_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= AXIL_RESP_OKAY;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= AXIL_RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    axil_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we_i    (rf_we),
        .waddr_i (c_idx[RF_AW-1:0]),
        .wdata_i (c_data),
        .wbe_i   (rf_be),
        .raddr_i (ar_idx[RF_AW-1:0]),
        .rdata_o (rf_rdata)
    );

endmodule

// File: doc/axil_reg_responder.md
# axil_reg_responder

AXI4-Lite slave that serves a word-addressed register bank; it is the responding end for the AXI-Lite write and read handlers that our generated HLS datapaths use as initiators. It accepts write address/data, commits byte-strobed writes and returns B responses, and it accepts read addresses and returns R data. It sits on the memory side of the AXI-Lite link, typically instantiated in testbenches and small SoC wrappers as the target of HLS-generated load/store traffic.

## Interface
- DATA_WIDTH, 32, data bus width in bits; a multiple of 8.
- ADDR_WIDTH, 7, byte-address width; the word index is addr[ADDR_WIDTH-1:2].
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
- DEPTH, 16, number of words in the bank; must satisfy DEPTH <= 2^(ADDR_WIDTH-2).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- s_axil_awaddr  in  ADDR_WIDTH  write byte address.
- s_axil_awvalid  in  1 / s_axil_awready  out  1  write-address handshake.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  byte enables.
- s_axil_wvalid  in  1 / s_axil_wready  out  1  write-data handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid  out  1 / s_axil_bready  in  1  write-response handshake.
- s_axil_araddr  in  ADDR_WIDTH  read byte address.
- s_axil_arvalid  in  1 / s_axil_arready  out  1  read-address handshake.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1 / s_axil_rready  in  1  read-data handshake.

## Operation
- Bank: DEPTH words of DATA_WIDTH bits; all words reset to 0.
- Decode: idx = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. If idx >= DEPTH, the access is out of range: the response is SLVERR (2'b10), writes are dropped, and read data is 0. In-range responses are OKAY (2'b00).
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - awready = (W_IDLE | W_HAVE_DATA); wready = (W_IDLE | W_HAVE_ADDR).
  - W_IDLE: AW and W handshakes in the same cycle -> commit, then W_RESP. AW only -> latch the address, then W_HAVE_ADDR. W only -> latch data and strobe, then W_HAVE_DATA.
  - W_HAVE_ADDR: W handshake -> commit, then W_RESP. W_HAVE_DATA: AW handshake -> commit, then W_RESP.
  - Commit: for each strobe bit i set, byte i of the word is written at the clock edge that enters W_RESP; bresp is registered on the same edge.
  - W_RESP: bvalid = 1 and bresp is stable. bvalid & bready -> W_IDLE. A write with wstrb = 0 is legal and completes with OKAY and no data change.
- Read FSM states: R_IDLE, R_RESP.
  - arready = R_IDLE. An AR handshake registers rdata and rresp, then the FSM enters R_RESP.
  - R_RESP: rvalid = 1; rdata and rresp are held stable until rvalid & rready, then R_IDLE.
- The read and write channels are independent and may be active concurrently.

## Timing
- Reset (asynchronous, immediate): both FSMs go to IDLE; bvalid = rvalid = 0; bresp = rresp = 2'b00; rdata = 0; awready = wready = arready = 1; the bank is cleared. Pending transactions are discarded with no response.
- Write latency: the final AW/W handshake at edge N gives bvalid = 1 from cycle N+1. Minimum write throughput is one write per 2 cycles.
- Read latency: an AR handshake at edge N gives rvalid = 1 from cycle N+1. Minimum read throughput is one read per 2 cycles.
- Back-to-back: B/R handshake at edge N gives ready high again in cycle N+1. Ready is never asserted in the same cycle as the response handshake.
- Same-edge read and write to the same word: the read returns the pre-write value.
- A stalled bready/rready holds the response indefinitely, and the corresponding address channel stays not-ready.

## Configuration
- AXIL_REG_WSTRB_EN defined: s_axil_wstrb is honoured per byte.
- AXIL_REG_WSTRB_EN undefined: s_axil_wstrb is ignored and every in-range write updates the full word. Port widths are unchanged.

## Structure
- Shared package axil_pkg holds the response codes (AXIL_RESP_OKAY = 2'b00, AXIL_RESP_SLVERR = 2'b10) and the write/read FSM state encodings.
- Sub-module axil_regfile (parameters DATA_WIDTH and DEPTH) holds the storage: asynchronous clear, one strobe-masked write port and one combinational read port. The top level holds both FSMs, decode and response registers.

## Test plan
- Simultaneous AW/W: addr 0x08, wdata 0xDEADBEEF, wstrb 4'hF -> bvalid next cycle with bresp 0. A following read of 0x08 returns 0xDEADBEEF with rvalid one cycle after AR.
- W three cycles before AW: wdata 0x12345678, then AW 0x04 -> wready low after the W handshake; bvalid one cycle after AW. Reading 0x04 returns 0x12345678.
- Strobe: word 0x0C = 0xAABBCCDD, then write 0x11223344 with wstrb 4'b0101 -> readback 0xAA22CC44 with the macro defined, 0x11223344 with it undefined.
- Out of range with DEPTH 16: write to 0x40 -> bresp 2'b10 and no word changes. Read of 0x40 -> rresp 2'b10 and rdata 0.
- Backpressure: rready held low for 5 cycles -> rvalid and rdata stable and arready low throughout; arready high one cycle after the handshake.
- Reset mid-transaction: assert rst while in W_RESP -> bvalid drops immediately, all readies are 1 after release, and reading 0x08 returns 0.
